// File: rtl/axi_write_buffer.sv
// axi_write_buffer: posted single-beat write FIFO draining in order to AXI AW/W/B with address-hazard check
module axi_write_buffer #(
  parameter int DEPTH = 4,
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_data,
  input  logic [3:0]  s_strb,
  input  logic [2:0]  s_size,
  input  logic [31:0] chk_addr,
  output logic        chk_hit,
  output logic        empty,
  output logic        bus_err,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_t;
  state_t state, state_n;
  logic [31:0] mem_addr [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [3:0] mem_strb [DEPTH];
  logic [2:0] mem_size [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [DEPTH-1:0] vld, match;
  logic aw_done, w_done, aw_hs, w_hs, push, pop, unused;
  assign unused = ^{bid, chk_addr[1:0]};
  assign s_ready = count != (AW+1)'(DEPTH);
  assign push = s_valid & s_ready;
  assign pop = bready & bvalid;
  assign awvalid = state == SEND & !aw_done;
  assign wvalid = state == SEND & !w_done;
  assign bready = state == WAIT_B;
  assign aw_hs = awvalid & awready;
  assign w_hs = wvalid & wready;
  assign empty = count == '0 & state == IDLE;
  assign chk_hit = |(vld & match);
  assign awid = AXI_ID;
  assign wid = AXI_ID;
  assign awlen = '0;
  assign awburst = 2'b01;
  assign awlock = '0;
  assign awcache = '0;
  assign awprot = '0;
  assign wlast = 1'b1;
  assign awaddr = mem_addr[rd_ptr];
  assign awsize = mem_size[rd_ptr];
  assign wdata = mem_data[rd_ptr];
  assign wstrb = mem_strb[rd_ptr];
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) match[i] = mem_addr[i][31:2] == chk_addr[31:2];
  end
  always_comb
    state_n = state == IDLE ? (count != '0 ? SEND : IDLE) :
              state == SEND ? ((aw_done | aw_hs) & (w_done | w_hs) ? WAIT_B : SEND) :
              (bvalid ? IDLE : WAIT_B);
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      vld <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= state_n;
      aw_done <= state_n == SEND & (aw_done | aw_hs);
      w_done <= state_n == SEND & (w_done | w_hs);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) vld[wr_ptr] <= 1'b1;
      if (pop) vld[rd_ptr] <= 1'b0;
      bus_err <= bus_err | (pop & |bresp);
    end
  always_ff @(posedge aclk)
    if (push) begin
      mem_addr[wr_ptr] <= s_addr;
      mem_data[wr_ptr] <= s_data;
      mem_strb[wr_ptr] <= s_strb;
      mem_size[wr_ptr] <= s_size;
    end
endmodule

// File: tb/tb_axi_write_buffer.sv
// tb_axi_write_buffer: randomized scoreboard bench for axi_write_buffer
module tb_axi_write_buffer;
  localparam int DEPTH = 4;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic [2:0] size;} ent_t;
  logic aclk = 0, aresetn = 0;
  logic s_valid = 0, s_ready;
  logic [31:0] s_addr = 0, s_data = 0, chk_addr = 0;
  logic [3:0] s_strb = 0;
  logic [2:0] s_size = 0;
  logic chk_hit, empty, bus_err;
  logic [3:0] awid, wid, wstrb, awcache, bid = 0;
  logic [31:0] awaddr, wdata;
  logic [7:0] awlen;
  logic [2:0] awsize, awprot;
  logic [1:0] awburst, awlock, bresp = 0;
  logic awvalid, awready = 0, wlast, wvalid, wready = 0, bvalid = 0, bready;
  int checks = 0, errors = 0;
  int push_p = 0, aw_p = 0, w_p = 0, b_p = 0, pushes = 0, pops = 0;
  ent_t q[$];
  logic aw_seen = 0, w_seen = 0, err_exp = 0;
  axi_write_buffer #(.DEPTH(DEPTH), .AXI_ID(4'd1)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_data(s_data), .s_strb(s_strb), .s_size(s_size), .chk_addr(chk_addr), .chk_hit(chk_hit),
    .empty(empty), .bus_err(bus_err), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready));
  always #5 aclk = ~aclk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
      s_valid = $urandom_range(0, 99) < push_p;
      s_addr = 32'h1FD0_F000 | ($urandom_range(0, 15) << 2);
      s_data = $urandom;
      s_strb = 4'($urandom);
      s_size = 3'($urandom_range(0, 2));
      chk_addr = 32'h1FD0_F000 | $urandom_range(0, 63);
      awready = $urandom_range(0, 99) < aw_p;
      wready = $urandom_range(0, 99) < w_p;
      bvalid = $urandom_range(0, 99) < b_p;
      bresp = $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      bid = 4'($urandom);
    end
  endtask
  always @(negedge aclk)
    if (!aresetn) begin
      q.delete();
      aw_seen = 0;
      w_seen = 0;
      err_exp = 0;
    end else begin
      logic hit;
      hit = 0;
      foreach (q[i]) if (q[i].addr[31:2] == chk_addr[31:2]) hit = 1;
      chk("s_ready", 32'(s_ready), 32'(q.size() < DEPTH));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("chk_hit", 32'(chk_hit), 32'(hit));
      chk("bus_err", 32'(bus_err), 32'(err_exp));
      if (awvalid) begin
        chk("aw_dup", 32'(aw_seen), 0);
        chk("aw_spurious", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          chk("awaddr", awaddr, q[0].addr);
          chk("awsize", 32'(awsize), 32'(q[0].size));
        end
      end
      if (wvalid) begin
        chk("w_dup", 32'(w_seen), 0);
        chk("w_spurious", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          chk("wdata", wdata, q[0].data);
          chk("wstrb", 32'(wstrb), 32'(q[0].strb));
        end
      end
      if (bready) chk("bready_early", 32'(aw_seen & w_seen), 1);
      if (awvalid && awready) aw_seen = 1;
      if (wvalid && wready) w_seen = 1;
      if (bvalid && bready && q.size() > 0) begin
        err_exp |= bresp != 0;
        void'(q.pop_front());
        aw_seen = 0;
        w_seen = 0;
        pops++;
      end
      if (s_valid && s_ready) begin
        q.push_back('{s_addr, s_data, s_strb, s_size});
        pushes++;
      end
    end
  initial begin
    #1;
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_chk_hit", 32'(chk_hit), 0);
    chk("awid", 32'(awid), 1);
    chk("wid", 32'(wid), 1);
    chk("awlen", 32'(awlen), 0);
    chk("awburst", 32'(awburst), 1);
    chk("wlast", 32'(wlast), 1);
    cycle(3);
    aresetn = 1;
    push_p = 100; aw_p = 0; w_p = 100; b_p = 100;
    cycle(15);
    push_p = 0; aw_p = 50;
    cycle(40);
    push_p = 40; aw_p = 50; w_p = 50; b_p = 50;
    cycle(1500);
    push_p = 70; aw_p = 30; w_p = 80; b_p = 30;
    cycle(500);
    begin
      int k;
      for (k = 0; k < 200 && !awvalid; k++) cycle(1);
      chk("awvalid_before_reset", 32'(awvalid), 1);
    end
    #3 aresetn = 0;
    #1;
    chk("mid_rst_awvalid", 32'(awvalid), 0);
    chk("mid_rst_wvalid", 32'(wvalid), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_bus_err", 32'(bus_err), 0);
    push_p = 0;
    cycle(2);
    aresetn = 1;
    push_p = 40; aw_p = 60; w_p = 60; b_p = 60;
    cycle(1000);
    push_p = 0; aw_p = 100; w_p = 100; b_p = 100;
    begin
      int k;
      for (k = 0; k < 200 && !(empty && q.size() == 0); k++) cycle(1);
      chk("drain_empty", 32'(empty), 1);
      chk("drain_model", 32'(q.size()), 0);
    end
    chk("traffic_seen", 32'(pops > 100), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_write_buffer.md
Name: axi_write_buffer

Overview:
- Posted-write FIFO between the d_cache single-beat write path and the AXI AW/W/B channels.
- Accepts uncached stores and write-throughs in one cycle, so the pipeline need not wait for the B response.
- Drains entries in order as single-beat AXI writes.
- Exposes an address-hazard check so the d_cache can stall an uncached read that hits a pending write.

Parameters:
DEPTH, 4, number of buffered write entries (power of two, >=2)
AXI_ID, 4'd1, constant driven on awid and wid

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous reset, active low
s_valid  in  1  d_cache presents a write
s_ready  out  1  buffer can accept (not full)
s_addr  in  32  physical write address
s_data  in  32  write data
s_strb  in  4  byte strobes
s_size  in  3  AXI size code (0/1/2)
chk_addr  in  32  physical address of a pending d_cache read
chk_hit  out  1  some valid entry matches chk_addr[31:2]
empty  out  1  no entries and no transaction in flight
bus_err  out  1  sticky: a B response had bresp != 0
awid  out  4  = AXI_ID
awaddr  out  32  head entry address
awlen  out  8  = 0
awsize  out  3  head entry size
awburst  out  2  = 2'b01
awlock  out  2  = 0
awcache  out  4  = 0
awprot  out  3  = 0
awvalid  out  1  address valid
awready  in  1  address accepted
wid  out  4  = AXI_ID
wdata  out  32  head entry data
wstrb  out  4  head entry strobes
wlast  out  1  = 1
wvalid  out  1  data valid
wready  in  1  data accepted
bid  in  4  ignored
bresp  in  2  write response
bvalid  in  1  response valid
bready  out  1  response ready

Behaviour:
- Clock and reset: one clock aclk; reset aresetn is asynchronous, active-low.
- Reset values:
  - FIFO pointers and count = 0.
  - State IDLE; awvalid = wvalid = bready = 0.
  - empty = 1, s_ready = 1, bus_err = 0, chk_hit = 0.
  - Stored entry contents are don't-care.
- Storage: circular FIFO of DEPTH entries {addr, data, strb, size}.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- Push: s_valid & s_ready writes the entry at wr_ptr and increments wr_ptr at the clock edge.
  - s_ready = (count != DEPTH), from registered count only.
  - A same-cycle pop does not make room for a push when full.
- Drain FSM:
  - IDLE: if count != 0, go to SEND and assert awvalid and wvalid from the head entry (next cycle).
  - SEND: awvalid and wvalid are held independently.
    - Each drops the cycle after its own handshake (awvalid&awready, wvalid&wready). Track them with aw_done and w_done flags.
    - The two handshakes may complete in either order or in the same cycle.
    - When both are done, go to WAIT_B with bready = 1.
  - WAIT_B: on bvalid, pop the head (rd_ptr+1, count-1), set bus_err if bresp != 0, and clear bready.
    - Next state is IDLE.
    - Back-to-back drain is not required: at least one IDLE cycle between entries.
- Head outputs (awaddr, awsize, wdata, wstrb) stay stable from first assertion of valid until that entry's B handshake. A push never disturbs the head.
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
- empty = (count == 0) & (state == IDLE).
- chk_hit:
  - Combinational OR over all valid entries (rd_ptr up to count, wrap-aware) of addr[31:2] == chk_addr[31:2].
  - Includes the entry in flight until its pop.
  - An entry being pushed this cycle is not included.
- Ordering is strictly FIFO; at most one AXI write is outstanding.
- Reset asserted mid-transaction: all state clears immediately and valids drop. The system resets the interconnect together with this block.

Test Plan:
- Single write: push addr 0x1FAF_F000, data 0xDEAD_BEEF, strb 0xF, size 2; awready/wready = 1, bvalid 2 cycles later -> one AW/W handshake with awaddr 0x1FAF_F000, wdata 0xDEAD_BEEF, wlast 1; empty returns to 1 the cycle after bvalid.
- Fill: DEPTH=4, awready held 0, push 5 writes back-to-back -> s_ready drops after the 4th; 5th accepted only after the first B. Drain order on awaddr is 0x00, 0x04, 0x08, 0x0C, 0x10.
- Split handshakes: wready in cycle 1 and awready in cycle 3 (then the reverse order) -> wvalid drops after cycle 1, awvalid after cycle 3; bready asserts only after both; no duplicate beats.
- Hazard: pending entry 0x1FD0_F010; chk_addr 0x1FD0_F012 -> chk_hit=1; chk_addr 0x1FD0_F014 -> 0; after its B pop, chk_hit=0.
- Push and pop in the same cycle with count=2 -> count stays 2, wrap-around across index 3->0 keeps correct order.
- bresp=2'b10 on a B response -> bus_err=1 and stays 1 through later OKAY responses until aresetn=0; reset asserted during SEND clears awvalid/wvalid asynchronously.
